// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Shared types and constants for the control sequencer:
//               FSM state encoding, opcode values, ALU move functions,
//               instruction field bit positions and the datapath control
//               bundle produced by the decoder.
// Revision    : 1.0  initial release
// ============================================================================
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcodes 0x0..0xB are plain ALU operations (FS = opcode)
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_LD   = 4'hD;
    localparam logic [3:0] OP_ST   = 4'hE;
    localparam logic [3:0] OP_BRH  = 4'hF;

    localparam logic [3:0] FS_MOVB = 4'hC;
    localparam logic [3:0] FS_MOVA = 4'h0;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DR_MSB  = 11;
    localparam int DR_LSB  = 9;
    localparam int SA_MSB  = 8;
    localparam int SA_LSB  = 6;
    localparam int SB_MSB  = 5;
    localparam int SB_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    // Everything the decoder drives towards ROM, RAM and datapath
    typedef struct packed {
        logic       rom_en;
        logic       ram_en;
        logic       mw;
        logic       mb;
        logic       mm;
        logic       md;
        logic       rw;
        logic [3:0] fs;
        logic [2:0] dr;
        logic [2:0] sa;
        logic [2:0] sb;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Bus bundle between the control sequencer and its environment
//               (instruction ROM, data RAM, register-file datapath).
//               master : sequencer side (drives controls, reads ROM/flags)
//               slave  : environment side
//               Inputs to sequencer : run, rom_data, V, C, N, Z
//               Outputs of sequencer: rom_en, rom_addr, ram_en, MW, DR, SA,
//                                     SB, AX, BX, DX, FS, MB, MM, MD, RW,
//                                     pc, halted
// Revision    : 1.0  initial release
// ============================================================================
interface control_sequencer_if #(
    parameter int nbit = 16,
    parameter int abit = 6
);
    logic            run;
    logic [nbit-1:0] rom_data;
    logic            V;
    logic            C;
    logic            N;
    logic            Z;

    logic            rom_en;
    logic [abit-1:0] rom_addr;
    logic            ram_en;
    logic            MW;
    logic [2:0]      DR;
    logic [2:0]      SA;
    logic [2:0]      SB;
    logic [3:0]      AX;
    logic [3:0]      BX;
    logic [3:0]      DX;
    logic [3:0]      FS;
    logic            MB;
    logic            MM;
    logic            MD;
    logic            RW;
    logic [abit-1:0] pc;
    logic            halted;

    modport master (
        input  run, rom_data, V, C, N, Z,
        output rom_en, rom_addr, ram_en, MW, DR, SA, SB, AX, BX, DX,
               FS, MB, MM, MD, RW, pc, halted
    );

    modport slave (
        output run, rom_data, V, C, N, Z,
        input  rom_en, rom_addr, ram_en, MW, DR, SA, SB, AX, BX, DX,
               FS, MB, MM, MD, RW, pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_decode
// Description : Purely combinational control decoder. From the current FSM
//               state and the instruction register it produces every ROM,
//               RAM and datapath control strobe. Anything not explicitly
//               driven for a state/opcode stays 0.
//               i_ir    : instruction register
//               i_state : current sequencer state
//               o_ctrl  : control bundle
// Revision    : 1.0  initial release
// ============================================================================
module sequencer_decode
    import control_sequencer_pkg::*;
#(
    parameter int nbit = 16
) (
    input  wire logic [nbit-1:0] i_ir,
    input  wire state_t          i_state,
    output ctrl_t                o_ctrl
);

    logic [3:0] w_op;
    logic [2:0] w_dr;
    logic [2:0] w_sa;
    logic [2:0] w_sb;
    logic [2:0] w_imm;

    assign w_op  = i_ir[OP_MSB:OP_LSB];
    assign w_dr  = i_ir[DR_MSB:DR_LSB];
    assign w_sa  = i_ir[SA_MSB:SA_LSB];
    assign w_sb  = i_ir[SB_MSB:SB_LSB];
    assign w_imm = i_ir[IMM_MSB:IMM_LSB];

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.rom_en = 1'b1;
            end
            ST_EXEC: begin
                case (w_op)
                    OP_LDI: begin
                        // B input takes the immediate constant, ALU passes B
                        o_ctrl.mb = 1'b1;
                        o_ctrl.fs = FS_MOVB;
                        o_ctrl.rw = 1'b1;
                        o_ctrl.dr = w_dr;
                    end
                    OP_LD: begin
                        // Address phase: RAM address comes from register A
                        o_ctrl.sa     = w_sa;
                        o_ctrl.ram_en = 1'b1;
                    end
                    OP_ST: begin
                        o_ctrl.sa     = w_sa;
                        o_ctrl.sb     = w_sb;
                        o_ctrl.ram_en = 1'b1;
                        o_ctrl.mw     = 1'b1;
                    end
                    OP_BRH: begin
                        // Only the branch form routes A through the ALU so
                        // that Z reflects it; the halt form drives nothing.
                        if (w_imm == 3'd0) begin
                            o_ctrl.fs = FS_MOVA;
                            o_ctrl.sa = w_sa;
                        end
                    end
                    default: begin
                        o_ctrl.fs = w_op;
                        o_ctrl.dr = w_dr;
                        o_ctrl.sa = w_sa;
                        o_ctrl.sb = w_sb;
                        o_ctrl.rw = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // Only a load reaches MEM: write RAM data back to DR
                o_ctrl.ram_en = 1'b1;
                o_ctrl.md     = 1'b1;
                o_ctrl.rw     = 1'b1;
                o_ctrl.dr     = w_dr;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle instruction sequencer. Fetches from an
//               instruction ROM, decodes ALU / LDI / LD / ST / BRZ / HALT
//               instructions and drives the datapath controls. Holds only
//               the state register, PC and IR; control decoding lives in
//               sequencer_decode.
//               clk_main : system clock, rising-edge
//               reset    : synchronous active-low reset
//               bus      : control_sequencer_if.master (ROM, RAM, datapath)
// Revision    : 1.0  initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int nbit = 16,
    parameter int abit = 6
) (
    input  wire logic             clk_main,
    input  wire logic             reset,
    control_sequencer_if.master   bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [abit-1:0]   r_pc;
    logic [abit-1:0]   w_pc_next;
    logic [nbit-1:0]   r_ir;

    logic [3:0]        w_op;
    logic [2:0]        w_dr;
    logic [2:0]        w_sb;
    logic [2:0]        w_imm;
    logic signed [5:0] w_off6;
    logic [abit-1:0]   w_offset;

    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;

    // Overflow, carry and negative flags play no part in sequencing
    logic              w_unused_flags;
    assign w_unused_flags = ^{bus.V, bus.C, bus.N};

    assign w_op   = r_ir[OP_MSB:OP_LSB];
    assign w_dr   = r_ir[DR_MSB:DR_LSB];
    assign w_sb   = r_ir[SB_MSB:SB_LSB];
    assign w_imm  = r_ir[IMM_MSB:IMM_LSB];
    // Branch offset is {dr,sb}, two's complement, sign-extended to PC width
    assign w_off6   = {w_dr, w_sb};
    assign w_offset = abit'(w_off6);

    always_ff @(posedge clk_main) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == ST_DECODE) begin
                r_ir <= bus.rom_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (bus.run) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_state_next = ST_EXEC;
                w_pc_next    = r_pc + abit'(1);
            end
            ST_EXEC: begin
                w_state_next = ST_FETCH;
                if (w_op == OP_LD) begin
                    w_state_next = ST_MEM;
                end else if (w_op == OP_BRH) begin
                    if (w_imm != 3'd0) begin
                        w_state_next = ST_HALT;
                    end else if (bus.Z) begin
                        // PC already points past the branch here
                        w_pc_next = r_pc + w_offset;
                    end
                end
            end
            ST_MEM: begin
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    sequencer_decode #(
        .nbit (nbit)
    ) u_decode (
        .i_ir    (r_ir),
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // While reset is held low every output is forced quiet, independent of
    // whatever state the register holds before the next edge.
    assign w_ctrl_out   = reset ? w_ctrl : '0;

    assign bus.rom_en   = w_ctrl_out.rom_en;
    assign bus.rom_addr = reset ? r_pc : '0;
    assign bus.ram_en   = w_ctrl_out.ram_en;
    assign bus.MW       = w_ctrl_out.mw;
    assign bus.MB       = w_ctrl_out.mb;
    assign bus.MM       = w_ctrl_out.mm;
    assign bus.MD       = w_ctrl_out.md;
    assign bus.RW       = w_ctrl_out.rw;
    assign bus.FS       = w_ctrl_out.fs;
    assign bus.DR       = w_ctrl_out.dr;
    assign bus.SA       = w_ctrl_out.sa;
    assign bus.SB       = w_ctrl_out.sb;
    assign bus.AX       = 4'h0;
    assign bus.BX       = 4'h0;
    assign bus.DX       = 4'h0;
    assign bus.pc       = reset ? r_pc : '0;
    assign bus.halted   = reset && (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A program-level
//               reference model walks the ROM contents instruction by
//               instruction and queues the externally visible control
//               pattern each cycle should show; a monitor compares every
//               non-quiet DUT cycle against the queue front.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_sequencer;

    logic clk_main = 1'b0;
    logic reset    = 1'b0;

    control_sequencer_if #(.nbit(16), .abit(6)) bus ();

    control_sequencer #(.nbit(16), .abit(6)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus.master)
    );

    always #5 clk_main = ~clk_main;

    typedef struct packed {
        logic [31:0] cyc;
        logic        rom_en;
        logic [5:0]  rom_addr;
        logic        ram_en;
        logic        mw;
        logic        mb;
        logic        mm;
        logic        md;
        logic        rw;
        logic [3:0]  fs;
        logic [2:0]  dr;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [3:0]  ax;
        logic [3:0]  bx;
        logic [3:0]  dx;
        logic [5:0]  pc;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] rom[64];
    bit          z_tab[64];
    int          checks   = 0;
    int          failures = 0;
    int          halt_at  = 32'h7fff_ffff;

    function automatic bit visible(input ev_t e);
        return e.rom_en | e.ram_en | e.mw | e.mb | e.mm | e.md | e.rw |
               (e.fs != 0) | (e.dr != 0) | (e.sa != 0) | (e.sb != 0) |
               (e.ax != 0) | (e.bx != 0) | (e.dx != 0);
    endfunction

    function automatic void expect_ev(input ev_t e, input int last);
        if (int'(e.cyc) <= last && visible(e)) exp_q.push_back(e);
    endfunction

    // Program-level model: one loop iteration per instruction. Fetch takes
    // place at cycle t, execute at t+2, the load write-back at t+3; the next
    // fetch follows 3 cycles later (4 for a load).
    task automatic build_model(input int first, input int last, output int halt_c);
        int          t;
        int          pc;
        int          npc;
        int          off;
        logic [15:0] w;
        logic [3:0]  op;
        logic [2:0]  dr, sa, sb, imm;
        ev_t         e;
        t      = first;
        pc     = 0;
        halt_c = -1;
        while (t <= last && halt_c < 0) begin
            e = '0; e.cyc = t; e.rom_en = 1'b1; e.rom_addr = 6'(pc); e.pc = 6'(pc);
            expect_ev(e, last);
            w   = rom[pc];
            op  = w[15:12]; dr = w[11:9]; sa = w[8:6]; sb = w[5:3]; imm = w[2:0];
            npc = (pc + 1) % 64;
            e = '0; e.cyc = t + 2; e.pc = 6'(npc); e.rom_addr = 6'(npc);
            if (op <= 4'hB) begin
                e.fs = op; e.dr = dr; e.sa = sa; e.sb = sb; e.rw = 1'b1;
            end else if (op == 4'hC) begin
                e.mb = 1'b1; e.fs = 4'hC; e.rw = 1'b1; e.dr = dr;
            end else if (op == 4'hD) begin
                e.sa = sa; e.ram_en = 1'b1;
                expect_ev(e, last);
                e = '0; e.cyc = t + 3; e.pc = 6'(npc); e.rom_addr = 6'(npc);
                e.ram_en = 1'b1; e.md = 1'b1; e.rw = 1'b1; e.dr = dr;
            end else if (op == 4'hE) begin
                e.sa = sa; e.sb = sb; e.ram_en = 1'b1; e.mw = 1'b1;
            end else if (imm == 3'd0) begin
                e.sa = sa;
                if (z_tab[pc]) begin
                    off = int'({dr, sb});
                    if (off >= 32) off = off - 64;
                    npc = (npc + off + 64) % 64;
                end
            end else begin
                halt_c = t + 3;
            end
            expect_ev(e, last);
            t  = t + ((op == 4'hD) ? 4 : 3);
            pc = npc;
        end
    endtask

    // ROM (data valid during the cycle after the fetch), Z per instruction
    // address, and noise on the ignored flags.
    initial begin
        bus.rom_data = '0;
        bus.V = 1'b0; bus.C = 1'b0; bus.N = 1'b0; bus.Z = 1'b0;
        forever begin
            @(negedge clk_main);
            bus.V = 1'($urandom_range(0, 1));
            bus.C = 1'($urandom_range(0, 1));
            bus.N = 1'($urandom_range(0, 1));
            if (bus.rom_en === 1'b1) begin
                bus.rom_data = rom[bus.rom_addr];
                bus.Z        = z_tab[bus.rom_addr];
            end
        end
    end

    // Monitor
    initial begin
        int  cyc;
        ev_t s;
        ev_t e;
        cyc = 0;
        forever begin
            @(posedge clk_main);
            #1;
            s = '0;
            s.rom_en = bus.rom_en; s.rom_addr = bus.rom_addr; s.ram_en = bus.ram_en;
            s.mw = bus.MW; s.mb = bus.MB; s.mm = bus.MM; s.md = bus.MD; s.rw = bus.RW;
            s.fs = bus.FS; s.dr = bus.DR; s.sa = bus.SA; s.sb = bus.SB;
            s.ax = bus.AX; s.bx = bus.BX; s.dx = bus.DX; s.pc = bus.pc;
            if (reset == 1'b0) begin
                cyc = 0;
                checks++;
                if (s !== '0 || bus.halted !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outputs actual=%h halted=%b required=0", s, bus.halted);
                end
            end else begin
                cyc++;
                s.cyc = cyc;
                if (visible(s)) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event cyc=%0d actual=%h required=none", cyc, s);
                    end else begin
                        e = exp_q.pop_front();
                        if (s !== e) begin
                            failures++;
                            $display("FAIL event cyc=%0d actual=%h required=%h", cyc, s, e);
                        end
                    end
                end
                checks++;
                if (bus.halted !== (cyc >= halt_at)) begin
                    failures++;
                    $display("FAIL halted cyc=%0d actual=%b required=%b", cyc, bus.halted, cyc >= halt_at);
                end
            end
        end
    end

    // Reset, release with run low for j cycles, then run until the
    // program halts (plus 10 cycles of run toggling) or until cycle 'last',
    // where reset is asserted to abort whatever is in flight.
    task automatic run_scenario(input int j, input int last);
        int halt_c;
        int a;
        @(negedge clk_main);
        reset   = 1'b0;
        bus.run = 1'b0;
        repeat (2) @(negedge clk_main);
        exp_q.delete();
        build_model(j + 1, last, halt_c);
        a = last;
        if (halt_c >= 0 && halt_c + 10 < last) a = halt_c + 10;
        halt_at = (halt_c >= 0) ? halt_c : 32'h7fff_ffff;
        reset   = 1'b1;
        bus.run = (j == 0);
        for (int c = 1; c <= a; c++) begin
            @(negedge clk_main);
            if (c == j)     bus.run = 1'b1;
            else if (c > j) bus.run = 1'($urandom_range(0, 1));
        end
        reset   = 1'b0;
        bus.run = 1'b0;
        @(negedge clk_main);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events actual=%0d_left required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    task automatic fill_rom(input logic [15:0] word);
        for (int i = 0; i < 64; i++) begin
            rom[i]   = word;
            z_tab[i] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] w;
        reset   = 1'b0;
        bus.run = 1'b0;
        repeat (3) @(negedge clk_main);

        // ADD, LD, ST, LDI, HALT
        fill_rom(16'h1000);
        rom[0] = 16'h2240;
        rom[1] = 16'hD680;
        rom[2] = 16'hE128;
        rom[3] = 16'hCC05;
        rom[4] = 16'hF001;
        run_scenario(0, 200);

        // Backward branch at 5 (offset -4): taken, then not taken
        fill_rom(16'h1000);
        for (int i = 0; i < 5; i++) rom[i] = 16'h3000 | 16'(i * 16'h0249);
        rom[5]   = 16'hFEA0;
        rom[6]   = 16'hF007;
        z_tab[5] = 1'b1;
        run_scenario(0, 60);
        z_tab[5] = 1'b0;
        run_scenario(2, 100);

        // Straight-line ALU code through address 63 and back to 0
        fill_rom(16'h0000);
        for (int i = 0; i < 64; i++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 11));
            rom[i] = w;
        end
        run_scenario(1, 64 * 3 + 20);

        // Reset during the write-back cycle of a load
        fill_rom(16'h2240);
        rom[0] = 16'hD680;
        run_scenario(0, 4);

        // Random programs
        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 64; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'hF && $urandom_range(0, 1) == 1) w[2:0] = 3'd0;
                rom[i]   = w;
                z_tab[i] = 1'($urandom_range(0, 1));
            end
            run_scenario($urandom_range(0, 3), $urandom_range(20, 300));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
